// File: rtl/apb_cfg_arbiter_if.sv
// Request/response channels for both requesters plus the APB bus of apb_cfg_arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface apb_cfg_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cfg_arbiter.sv
// Round-robin two-requester arbiter driving one APB SETUP/ACCESS transfer per grant.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_cfg_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_cfg_arbiter_if.master   bus,
    output logic                busy,
    output logic                grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              grant_id_q, grant_id_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic              rsp0_err_q, rsp0_err_d;
    logic              rsp1_err_q, rsp1_err_d;

    logic              grant;
    logic              rdy0, rdy1;
    logic              accept;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_rdata;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_cfg_arbiter: TIMEOUT must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // On contention the requester that did not win last time gets the bus.
    always_comb begin
        grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_q;
        end
    end

    assign rdy0   = (state_q == IDLE) && !grant;
    assign rdy1   = (state_q == IDLE) &&  grant;
    assign accept = (bus.req0_valid && rdy0) || (bus.req1_valid && rdy1);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_err_d   = rsp1_err_q;
        done         = 1'b0;
        done_err     = 1'b0;
        done_rdata   = '0;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SETUP;
                    last_d     = grant;
                    grant_id_d = grant;
                    paddr_d    = grant ? bus.req1_addr  : bus.req0_addr;
                    pwdata_d   = grant ? bus.req1_wdata : bus.req0_wdata;
                    pwrite_d   = grant ? bus.req1_write : bus.req0_write;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready) begin
                    done       = 1'b1;
                    done_err   = bus.pslverr;
                    done_rdata = pwrite_q ? '0 : bus.prdata;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    done       = 1'b1;
                    done_err   = 1'b1;
                    done_rdata = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Completion routes the result only to the requester that owns the transfer.
        if (done) begin
            state_d = IDLE;
            if (grant_id_q) begin
                rsp1_valid_d = 1'b1;
                rsp1_rdata_d = done_rdata;
                rsp1_err_d   = done_err;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_rdata_d = done_rdata;
                rsp0_err_d   = done_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            grant_id_q   <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp1_err   = rsp1_err_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.psel       = (state_q != IDLE);
    assign bus.penable    = (state_q == ACCESS);
    assign busy           = (state_q != IDLE);
    assign grant_id       = grant_id_q;

endmodule

// File: tb/tb_apb_cfg_arbiter.sv
// Bench for apb_cfg_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a transaction-timeline reference model.
module tb_apb_cfg_arbiter;

    logic clk;
    logic rst;
    logic busy;
    logic grant_id;

    apb_cfg_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_cfg_arbiter #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave: manual mode for directed tests, auto mode (memory + scripted waits) for random.
    bit          auto_mode = 1'b0;
    logic        man_pready = 1'b0;
    logic [31:0] man_prdata = '0;
    logic        man_err = 1'b0;
    logic [31:0] smem [0:7];
    int          waits [256];
    int          acc_cnt;
    int          cur_w;
    int          xfer_idx;

    assign bus.pready  = auto_mode ? (bus.penable && (acc_cnt == cur_w)) : man_pready;
    assign bus.prdata  = auto_mode ? smem[bus.paddr[4:2]] : man_prdata;
    assign bus.pslverr = auto_mode ? bus.paddr[11] : man_err;

    always @(posedge clk) begin
        if (rst) begin
            xfer_idx <= 0;
            acc_cnt  <= 0;
            cur_w    <= 0;
            for (int i = 0; i < 8; i++) smem[i] <= '0;
        end else begin
            if (bus.psel && !bus.penable) begin
                cur_w    <= waits[xfer_idx % 256];
                xfer_idx <= xfer_idx + 1;
            end
            acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
            if (auto_mode && bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.paddr[11])
                smem[bus.paddr[4:2]] <= bus.pwdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input bit w, input logic [11:0] a,
                           input logic [31:0] d);
        if (!id) begin
            bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    typedef struct {
        bit          id;
        bit          write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] s_rdata;
        bit          s_err;
        int          nwait;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int k, input vec_t v);
        string t;
        t = $sformatf("v%0d", k);
        @(posedge clk); #1;
        man_pready = 1'b0; man_prdata = v.s_rdata; man_err = v.s_err;
        set_req(v.id, 1'b1, v.write, v.addr, v.wdata);
        @(negedge clk);
        chk({t, "_ready"}, v.id ? bus.req1_ready : bus.req0_ready, 1);
        chk({t, "_other_ready"}, v.id ? bus.req0_ready : bus.req1_ready, 0);
        chk({t, "_idle_psel"}, bus.psel, 0);
        @(posedge clk); #1;
        set_req(v.id, 1'b0, ~v.write, ~v.addr, ~v.wdata);
        @(negedge clk);
        chk({t, "_setup_psel"}, bus.psel, 1);
        chk({t, "_setup_pen"}, bus.penable, 0);
        chk({t, "_setup_paddr"}, bus.paddr, v.addr);
        chk({t, "_setup_pwrite"}, bus.pwrite, v.write);
        chk({t, "_setup_pwdata"}, bus.pwdata, v.wdata);
        chk({t, "_grant_id"}, grant_id, v.id);
        chk({t, "_busy"}, busy, 1);
        for (int i = 0; i <= v.nwait; i++) begin
            @(posedge clk); #1;
            man_pready = (i == v.nwait);
            @(negedge clk);
            chk({t, "_acc_psel"}, bus.psel, 1);
            chk({t, "_acc_pen"}, bus.penable, 1);
            chk({t, "_acc_paddr"}, bus.paddr, v.addr);
            chk({t, "_acc_pwdata"}, bus.pwdata, v.wdata);
            chk({t, "_acc_norsp"}, {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        end
        @(posedge clk); #1;
        man_pready = 1'b0; man_prdata = 32'h5A5A5A5A; man_err = 1'b0;
        @(negedge clk);
        chk({t, "_rsp_valid"}, v.id ? bus.rsp1_valid : bus.rsp0_valid, 1);
        chk({t, "_rsp_other"}, v.id ? bus.rsp0_valid : bus.rsp1_valid, 0);
        chk({t, "_rsp_rdata"}, v.id ? bus.rsp1_rdata : bus.rsp0_rdata, v.e_rdata);
        chk({t, "_rsp_err"}, v.id ? bus.rsp1_err : bus.rsp0_err, v.e_err);
        chk({t, "_rsp_psel"}, bus.psel, 0);
        chk({t, "_rsp_busy"}, busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({t, "_pulse_end"}, v.id ? bus.rsp1_valid : bus.rsp0_valid, 0);
        chk({t, "_rdata_hold"}, v.id ? bus.rsp1_rdata : bus.rsp0_rdata, v.e_rdata);
        chk({t, "_err_hold"}, v.id ? bus.rsp1_err : bus.rsp0_err, v.e_err);
    endtask

    // Reference model state: one transfer timeline (accept cycle + wait count) and one pending response.
    int          acc_cyc, acc_w, rsp_cyc, m_xfer;
    bit          m_last, m_gid, rsp_id, rsp_err;
    logic [11:0] acc_addr;
    logic [31:0] acc_wdata, rsp_rdata;
    bit          acc_write;
    logic [31:0] shadow [0:7];
    bit          vq [2];
    bit          wq [2];
    logic [11:0] aq [2];
    logic [31:0] dq [2];
    bit          acc_prev [2];
    bit          exp_busy, exp_pen, g;
    int          nacc, last_c, pen_cycles;
    bit          exp_g, got;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 256; i++) waits[i] = $urandom_range(0, 3);

        vecs[0] = '{1'b0, 1'b1, 12'h004, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 0, 32'h00000000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 12'h004, 32'h11111111, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 12'h008, 32'h00000000, 32'h0BAD0BAD, 1'b1, 0, 32'h0BAD0BAD, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 12'h010, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1, 32'h00000000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 12'h00C, 32'h00000000, 32'h13572468, 1'b0, 3, 32'h13572468, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 12'h020, 32'h01234567, 32'hFFFFFFFF, 1'b1, 2, 32'h00000000, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        chk("rst_rsp_rdata", {bus.rsp0_rdata, bus.rsp1_rdata}, 64'h0);
        chk("rst_rsp_err", {bus.rsp0_err, bus.rsp1_err}, 2'b00);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_pwrite", bus.pwrite, 0);

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // Reset during ACCESS: transfer is dropped silently and the pointer returns to favour req0.
        @(posedge clk); #1;
        man_pready = 1'b0; man_prdata = 32'h00000077; man_err = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 12'h004, '0);
        @(negedge clk);
        chk("abort_accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; man_pready = 1'b1;
        @(negedge clk);
        chk("abort_in_access", bus.penable, 1);
        @(posedge clk); #1;
        rst = 1'b0; man_pready = 1'b0;
        @(negedge clk);
        chk("abort_psel", bus.psel, 0);
        chk("abort_penable", bus.penable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_norsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        chk("abort_rdata_cleared", bus.rsp0_rdata, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_norsp_later", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);

        // Both requesters held valid: grants alternate 0,1,0,1 at one per three cycles.
        @(posedge clk); #1;
        man_pready = 1'b1; man_err = 1'b0; man_prdata = '0;
        set_req(1'b0, 1'b1, 1'b1, 12'h040, 32'h00000001);
        set_req(1'b1, 1'b1, 1'b0, 12'h044, 32'h00000002);
        nacc = 0; last_c = -1; exp_g = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rr_ready_excl", bus.req0_ready && bus.req1_ready, 0);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("rr_grant", bus.req1_ready, exp_g);
                if (nacc > 0) chk("rr_spacing", c - last_c, 3);
                last_c = c;
                nacc++;
                exp_g = ~exp_g;
            end
            @(posedge clk); #1;
        end
        chk("rr_count", nacc, 4);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #1 man_pready = 1'b0;

        // Slave that never answers on its own.
        man_prdata = 32'hFEEDFACE; man_err = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 12'h018, '0);
        @(negedge clk);
        chk("stall_accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        pen_cycles = 0; got = 1'b0;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.rsp0_valid) begin
                got = 1'b1;
                chk("tmo_err", bus.rsp0_err, 1);
                chk("tmo_rdata", bus.rsp0_rdata, 0);
                chk("tmo_psel", bus.psel, 0);
            end else if (bus.penable) begin
                pen_cycles++;
            end
        end
        chk("tmo_seen", got, 1);
        chk("tmo_len", pen_cycles, 16);
`else
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.penable && !bus.rsp0_valid) pen_cycles++;
        end
        chk("stall_hold", pen_cycles, 20);
        @(posedge clk); #1;
        man_pready = 1'b1;
        @(posedge clk); #1;
        man_pready = 1'b0;
        @(negedge clk);
        chk("stall_rsp", bus.rsp0_valid, 1);
        chk("stall_rdata", bus.rsp0_rdata, 32'hFEEDFACE);
        chk("stall_err", bus.rsp0_err, 0);
`endif

        // Randomized traffic against the timeline model.
        @(posedge clk); #1;
        auto_mode = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1'b1; m_gid = 1'b0; acc_cyc = -100; acc_w = 0; rsp_cyc = -100; m_xfer = 0;
        rsp_id = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
        acc_addr = '0; acc_wdata = '0; acc_write = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        for (int r = 0; r < 2; r++) begin
            vq[r] = 1'b0; wq[r] = 1'b0; aq[r] = '0; dq[r] = '0; acc_prev[r] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (acc_prev[r]) begin
                    vq[r] = 1'b0;
                end else if (vq[r] && $urandom_range(0, 19) == 0) begin
                    vq[r] = 1'b0;
                end else if (!vq[r] && $urandom_range(0, 1) == 0) begin
                    vq[r] = 1'b1;
                    wq[r] = 1'($urandom_range(0, 1));
                    aq[r] = (($urandom_range(0, 7) == 0) ? 12'h800 : 12'h000) | 12'($urandom_range(0, 7) * 4);
                    dq[r] = $urandom;
                end
                set_req(r[0], vq[r], wq[r], aq[r], dq[r]);
            end
            @(negedge clk);
            exp_busy = (cyc > acc_cyc) && (cyc <= acc_cyc + 2 + acc_w);
            exp_pen  = exp_busy && (cyc >= acc_cyc + 2);
            chk("r_busy", busy, exp_busy);
            chk("r_psel", bus.psel, exp_busy);
            chk("r_penable", bus.penable, exp_pen);
            if (exp_busy) begin
                chk("r_paddr", bus.paddr, acc_addr);
                chk("r_pwrite", bus.pwrite, acc_write);
                chk("r_pwdata", bus.pwdata, acc_wdata);
            end
            chk("r_grant_id", grant_id, m_gid);
            chk("r_ready_excl", bus.req0_ready && bus.req1_ready, 0);
            g = (vq[0] && vq[1]) ? ~m_last : vq[1];
            if (vq[0]) chk("r_ready0", bus.req0_ready, !exp_busy && !g);
            if (vq[1]) chk("r_ready1", bus.req1_ready, !exp_busy && g);
            chk("r_rsp0_valid", bus.rsp0_valid, (cyc == rsp_cyc) && !rsp_id);
            chk("r_rsp1_valid", bus.rsp1_valid, (cyc == rsp_cyc) && rsp_id);
            if (cyc == rsp_cyc) begin
                chk("r_rsp_rdata", rsp_id ? bus.rsp1_rdata : bus.rsp0_rdata, rsp_rdata);
                chk("r_rsp_err", rsp_id ? bus.rsp1_err : bus.rsp0_err, rsp_err);
            end
            acc_prev[0] = 1'b0;
            acc_prev[1] = 1'b0;
            if (!exp_busy && vq[g]) begin
                acc_cyc   = cyc;
                acc_w     = waits[m_xfer % 256];
                m_xfer++;
                acc_addr  = aq[g];
                acc_write = wq[g];
                acc_wdata = dq[g];
                m_last    = g;
                m_gid     = g;
                acc_prev[g] = 1'b1;
                rsp_cyc   = cyc + 3 + acc_w;
                rsp_id    = g;
                rsp_err   = aq[g][11];
                rsp_rdata = wq[g] ? 32'h0 : shadow[aq[g][4:2]];
                if (wq[g] && !aq[g][11]) shadow[aq[g][4:2]] = dq[g];
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
